// File: rtl/accelerator_bus_scheduler.sv
// Round-robin bus scheduler for FFT/FIR/IIR accelerators with burst limiting and a turnaround gap.
// Optional per-accelerator grant counters are enabled by defining ACCEL_BUS_SCHED_STATS_EN.
module accelerator_bus_scheduler #(
  parameter int BURST_LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fft_req,
  input  logic        fir_req,
  input  logic        iir_req,
  output logic        fft_enable,
  output logic        fir_enable,
  output logic        iir_enable,
  output logic [1:0]  owner,
  output logic        busy
`ifdef ACCEL_BUS_SCHED_STATS_EN
  ,
  output logic [15:0] fft_grants,
  output logic [15:0] fir_grants,
  output logic [15:0] iir_grants
`endif
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] BURST_MAX = CW'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, GRANT, TURNAROUND} state_t;

  state_t        r_state, w_nextState;
  logic [CW-1:0] r_burstCnt, w_nextCnt;
  logic [1:0]    r_owner, w_nextOwner;
  logic [1:0]    r_lastOwner, w_nextLast;
  logic [1:0]    w_winner;
  logic          w_ownerReq;
  logic          w_newGrant;

  // Search starts at the requester just after the previous owner.
  always_comb begin
    w_winner = 2'd0;
    case (r_lastOwner)
      2'd1: begin
        if (fir_req)      w_winner = 2'd2;
        else if (iir_req) w_winner = 2'd3;
        else if (fft_req) w_winner = 2'd1;
      end
      2'd2: begin
        if (iir_req)      w_winner = 2'd3;
        else if (fft_req) w_winner = 2'd1;
        else if (fir_req) w_winner = 2'd2;
      end
      default: begin
        if (fft_req)      w_winner = 2'd1;
        else if (fir_req) w_winner = 2'd2;
        else if (iir_req) w_winner = 2'd3;
      end
    endcase
  end

  always_comb begin
    w_ownerReq = 1'b0;
    case (r_owner)
      2'd1:    w_ownerReq = fft_req;
      2'd2:    w_ownerReq = fir_req;
      2'd3:    w_ownerReq = iir_req;
      default: w_ownerReq = 1'b0;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_burstCnt;
    w_nextOwner = r_owner;
    w_nextLast  = r_lastOwner;
    w_newGrant  = 1'b0;
    case (r_state)
      IDLE, TURNAROUND: begin
        if (w_winner != 2'd0) begin
          w_nextState = GRANT;
          w_nextOwner = w_winner;
          w_nextLast  = w_winner;
          w_nextCnt   = CW'(1);
          w_newGrant  = 1'b1;
        end else begin
          w_nextState = IDLE;
          w_nextOwner = 2'd0;
          w_nextCnt   = '0;
        end
      end
      GRANT: begin
        // The first enable cycle is already counted, so BURST_MAX ends the burst on time.
        if (!w_ownerReq || (r_burstCnt == BURST_MAX)) begin
          w_nextState = TURNAROUND;
          w_nextOwner = 2'd0;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_burstCnt + CW'(1);
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextOwner = 2'd0;
        w_nextCnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_burstCnt  <= '0;
      r_owner     <= 2'd0;
      r_lastOwner <= 2'd3;
      fft_enable  <= 1'b0;
      fir_enable  <= 1'b0;
      iir_enable  <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_burstCnt  <= w_nextCnt;
      r_owner     <= w_nextOwner;
      r_lastOwner <= w_nextLast;
      fft_enable  <= (w_nextOwner == 2'd1);
      fir_enable  <= (w_nextOwner == 2'd2);
      iir_enable  <= (w_nextOwner == 2'd3);
    end
  end

  assign owner = r_owner;
  assign busy  = (r_state != IDLE);

`ifdef ACCEL_BUS_SCHED_STATS_EN
  logic [15:0] r_fftGrants, r_firGrants, r_iirGrants;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fftGrants <= 16'd0;
      r_firGrants <= 16'd0;
      r_iirGrants <= 16'd0;
    end else if (w_newGrant) begin
      case (w_nextOwner)
        2'd1: if (r_fftGrants != 16'hFFFF) r_fftGrants <= r_fftGrants + 16'd1;
        2'd2: if (r_firGrants != 16'hFFFF) r_firGrants <= r_firGrants + 16'd1;
        2'd3: if (r_iirGrants != 16'hFFFF) r_iirGrants <= r_iirGrants + 16'd1;
        default: ;
      endcase
    end
  end

  assign fft_grants = r_fftGrants;
  assign fir_grants = r_firGrants;
  assign iir_grants = r_iirGrants;
`endif

endmodule

// File: doc/accelerator_bus_scheduler.md
ACCELERATOR_BUS_SCHEDULER -- requirements
Module: accelerator_bus_scheduler

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 16, giving the maximum consecutive grant cycles per ownership (legal 1..256).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports fft_req, fir_req and iir_req, input, 1 bit each: the accelerator requests bus ownership; held high while it has data to move.
REQ-005 The block SHALL have ports fft_enable, fir_enable and iir_enable, output, 1 bit each: registered, at most one high; these drive the data bus controller enables.
REQ-006 The block SHALL have port owner, output, 2 bits: 0=none, 1=FFT, 2=FIR, 3=IIR; registered, consistent with the enables.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-008 The state machine SHALL have three states: IDLE, GRANT and TURNAROUND.
REQ-009 In IDLE with no request, all enables SHALL be 0 and owner SHALL be 0.
REQ-010 In IDLE, if any request is sampled high at edge n, the block SHALL enter GRANT with the winner's enable high from edge n, i.e. one cycle of request-to-enable latency.
REQ-011 Arbitration SHALL be round-robin in the order FFT->FIR->IIR->FFT, starting the search at the requester after last_owner; last_owner updates on each grant.
REQ-012 In GRANT, a burst counter SHALL count enable-high cycles; the counter is $clog2(BURST_LEN)+1 bits wide and clears on each new grant.
REQ-013 GRANT SHALL go to TURNAROUND when the owner's request is sampled low or when the counter reaches BURST_LEN, whichever comes first; the enable is therefore high for at most BURST_LEN cycles.
REQ-014 In TURNAROUND, all enables SHALL be 0 for exactly one cycle so that tri-state drivers do not overlap.
REQ-015 From TURNAROUND, if any request is high, the block SHALL go directly to GRANT using round-robin; otherwise it SHALL go to IDLE.
REQ-016 The current owner SHALL NOT be re-granted back-to-back while another requester is pending.
REQ-017 If the current owner is the sole requester, it SHALL be re-granted after the turnaround cycle.
REQ-018 Requests changing during GRANT for non-owners SHALL NOT affect the current grant.
REQ-019 With BURST_LEN=1, each grant SHALL last exactly 1 cycle, followed by 1 turnaround cycle.
REQ-020 With simultaneous requests at reset exit, FFT SHALL win first.

Reset
REQ-021 Assertion of rst_n=0 at any time, including mid-burst, SHALL immediately force: state IDLE, all enables 0, owner 0, busy 0, burst counter 0, and last_owner IIR.
REQ-022 After rst_n deasserts, the first grant SHALL follow REQ-010 timing.

Configuration
REQ-023 The macro ACCEL_BUS_SCHED_STATS_EN, when defined, SHALL add outputs fft_grants, fir_grants and iir_grants, 16 bits each, which increment once per new grant to that accelerator, saturate at 16'hFFFF, and reset to 0.
REQ-024 When ACCEL_BUS_SCHED_STATS_EN is undefined, those ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-025 Reset, then fir_req=1 alone held for 5 cycles then dropped, with BURST_LEN=16 -> fir_enable high 5 cycles starting one cycle after the request; owner=2; then 1 TURNAROUND cycle, then IDLE, with busy low.
REQ-026 All three requests held high, BURST_LEN=4 -> grant sequence FFT(4 cycles), gap(1), FIR(4), gap(1), IIR(4), gap(1), FFT...; never two enables high at once.
REQ-027 fft_req held high alone, BURST_LEN=4 -> fft_enable pattern 4 high, 1 low, repeating.
REQ-028 rst_n pulled low on cycle 2 of an IIR grant -> iir_enable, owner and busy go 0 asynchronously; after release with fft_req=1 and iir_req=1, FFT is granted first.
REQ-029 BURST_LEN=1, with fft_req and fir_req high -> enables alternate FFT, gap, FIR, gap, and so on.
REQ-030 With ACCEL_BUS_SCHED_STATS_EN defined, 3 FIR grants -> fir_grants=3 and the other counters 0; forcing 65536 grants -> the counter holds 16'hFFFF.
